// File: rtl/proc_run_ctrl_if.sv
// Host load stream and instruction-memory write port of the run controller.
interface proc_run_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [DATA_W-1:0] mem_d;

  // controller side
  modport slave  (input  ld_valid, ld_data, ld_last,
                  output ld_ready, mem_we, mem_a, mem_d);
  // host / memory side
  modport master (output ld_valid, ld_data, ld_last,
                  input  ld_ready, mem_we, mem_a, mem_d);
endinterface

// File: rtl/proc_run_ctrl.sv
// Load/run sequencer in front of the Proc core: streams a program into
// instruction memory, then runs exec until halt-PC, budget or abort.
module proc_run_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 512,
  parameter int CYC_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  proc_run_ctrl_if.slave     bus,
  input  logic               start_load,
  input  logic               run_start,
  input  logic [CYC_W-1:0]   run_cycles,
  input  logic [31:0]        halt_pc,
  input  logic [31:0]        pc_in,
  input  logic               abort,
  output logic               exec,
  output logic               busy,
  output logic               done,
  output logic [1:0]         status,
  output logic [ADDR_W:0]    words_loaded,
  output logic [CYC_W-1:0]   cycles_run
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_e;

  localparam logic [1:0] ST_HALT   = 2'b00;
  localparam logic [1:0] ST_BUDGET = 2'b01;
  localparam logic [1:0] ST_OVF    = 2'b10;
  localparam logic [1:0] ST_ABORT  = 2'b11;
  // words_loaded doubles as the write address; this is the last legal slot
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(MAX_WORDS - 1);

  state_e              state_q, state_d;
  logic                ld_ready_q, ld_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_a_q, mem_a_d;
  logic [DATA_W-1:0]   mem_d_q, mem_d_d;
  logic                exec_q, exec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [1:0]          status_q, status_d;
  logic [ADDR_W:0]     words_q, words_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CYC_W-1:0]    budget_q, budget_d;
  logic [CYC_W-1:0]    cyc_inc;

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    ld_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    exec_d     = 1'b0;
    status_d   = status_q;
    words_d    = words_q;
    cyc_d      = cyc_q;
    budget_d   = budget_q;
    cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_load) begin
          state_d    = S_LOAD;
          words_d    = '0;
          ld_ready_d = 1'b1;
        end else if (run_start) begin
          cyc_d    = '0;
          budget_d = run_cycles;
          if (run_cycles == '0) begin
            state_d  = S_DONE;
            status_d = ST_BUDGET;
          end else begin
            state_d = S_RUN;
            exec_d  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else begin
          ld_ready_d = 1'b1;
          if (bus.ld_valid && ld_ready_q) begin
            mem_we_d = 1'b1;
            mem_a_d  = words_q[ADDR_W-1:0];
            mem_d_d  = bus.ld_data;
            words_d  = words_q + 1'b1;
            if (bus.ld_last) begin
              state_d    = S_IDLE;
              ld_ready_d = 1'b0;
            end else if (words_q == LAST_IDX) begin
              state_d    = S_DONE;
              status_d   = ST_OVF;
              ld_ready_d = 1'b0;
            end
          end
        end
      end
      S_RUN: begin
        // exec was high this cycle, so it is counted whatever ends the run
        cyc_d = cyc_inc;
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (pc_in == halt_pc) begin
          state_d  = S_DONE;
          status_d = ST_HALT;
        end else if (cyc_inc == budget_q) begin
          state_d  = S_DONE;
          status_d = ST_BUDGET;
        end else begin
          exec_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ld_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      exec_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      words_q    <= '0;
      cyc_q      <= '0;
      budget_q   <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= ld_ready_d;
      mem_we_q   <= mem_we_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      exec_q     <= exec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      words_q    <= words_d;
      cyc_q      <= cyc_d;
      budget_q   <= budget_d;
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_a    = mem_a_q;
  assign bus.mem_d    = mem_d_q;
  assign exec         = exec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign status       = status_q;
  assign words_loaded = words_q;
  assign cycles_run   = cyc_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Randomized bench for proc_run_ctrl, built with MAX_WORDS=4 so the
// overflow boundary is reachable; expectations come from a small model.
module tb_proc_run_ctrl;
  localparam int AW = 9, DW = 32, MW = 4, CW = 32;

  logic          clk = 1'b0;
  logic          rst, start_load, run_start, abort;
  logic [CW-1:0] run_cycles;
  logic [31:0]   halt_pc, pc_in;
  logic          exec, busy, done;
  logic [1:0]    status;
  logic [AW:0]   words_loaded;
  logic [CW-1:0] cycles_run;

  proc_run_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  proc_run_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_WORDS(MW), .CYC_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .start_load(start_load), .run_start(run_start), .run_cycles(run_cycles),
    .halt_pc(halt_pc), .pc_in(pc_in), .abort(abort),
    .exec(exec), .busy(busy), .done(done), .status(status),
    .words_loaded(words_loaded), .cycles_run(cycles_run)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;

  // Monitor: every memory write, every exec-high cycle, any we/exec overlap
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t wr_q[$];
  int  exec_total = 0;
  int  overlap = 0;
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) wr_q.push_back('{a: bus.mem_a, d: bus.mem_d});
    if (exec === 1'b1) exec_total <= exec_total + 1;
    if (exec === 1'b1 && bus.mem_we === 1'b1) overlap <= overlap + 1;
  end

  logic [31:0] ld_words[8];
  logic        ld_rdy[8];

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Stream n words; word last_at carries ld_last (-1: none); gaps between words
  task automatic drive_load(input int n, input int last_at, input int gmin, input int gmax);
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    for (int w = 0; w < n; w++) begin
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      ld_rdy[w]    = bus.ld_ready;
      ld_words[w]  = $urandom;
      bus.ld_valid = 1'b1;
      bus.ld_data  = ld_words[w];
      bus.ld_last  = (w == last_at);
      @(negedge clk);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  // Start a run; pc_in equals the 1-based exec-cycle index; abort in cycle abort_at
  task automatic drive_run(input logic [31:0] budget, input logic [31:0] hpc,
                           input int abort_at, output int tout);
    tout = 0;
    @(negedge clk);
    run_start = 1'b1; run_cycles = budget; halt_pc = hpc; pc_in = '0; abort = 1'b0;
    @(negedge clk);
    run_start = 1'b0;
    for (int i = 1; done !== 1'b1; i++) begin
      if (i > 300) begin tout = 1; break; end
      pc_in = 32'(i);
      abort = (i == abort_at);
      @(negedge clk);
    end
    abort = 1'b0; pc_in = '0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({exec, busy, done, status, words_loaded, cycles_run} !== '0) begin
      errs++; $display("FAIL reset_ctrl: got %b, want all zero",
                       {exec, busy, done, status, words_loaded, cycles_run});
    end
    checks++;
    if ({bus.ld_ready, bus.mem_we, bus.mem_a, bus.mem_d} !== '0) begin
      errs++; $display("FAIL reset_bus: got %h, want 0",
                       {bus.ld_ready, bus.mem_we, bus.mem_a, bus.mem_d});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load(input string nm, input int n, input int last_at,
                           input int gmin, input int gmax);
    int base, m;
    logic ovf;
    // model: words accepted until ld_last or MW words, whichever comes first
    m = 0;
    for (int w = 0; w < n; w++) begin
      m++;
      if (w == last_at || m == MW) break;
    end
    ovf = !(last_at >= 0 && last_at < m);
    base = wr_q.size();
    drive_load(n, last_at, gmin, gmax);
    checks++;
    if (wr_q.size() - base != m) begin
      errs++; $display("FAIL %s_nwrites: got %0d, want %0d", nm, wr_q.size() - base, m);
    end
    for (int i = 0; i < m && base + i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[base+i].a !== AW'(i) || wr_q[base+i].d !== ld_words[i]) begin
        errs++; $display("FAIL %s_write%0d: got a=%0d d=%h, want a=%0d d=%h", nm, i,
                         wr_q[base+i].a, wr_q[base+i].d, i, ld_words[i]);
      end
    end
    for (int w = 0; w < n; w++) begin
      checks++;
      if (ld_rdy[w] !== (w < m)) begin
        errs++; $display("FAIL %s_ready%0d: got %b, want %b", nm, w, ld_rdy[w], (w < m));
      end
    end
    checks++;
    if (words_loaded !== (AW+1)'(m) || busy !== 1'b0 || done !== ovf) begin
      errs++; $display("FAIL %s_end: got words=%0d busy=%b done=%b, want %0d 0 %b",
                       nm, words_loaded, busy, done, m, ovf);
    end
    if (ovf) begin
      checks++;
      if (status !== 2'b10) begin
        errs++; $display("FAIL %s_status: got %b, want 10", nm, status);
      end
    end
  endtask

  // k: halt in k-th exec cycle (0: unreachable); j: abort in j-th exec cycle (0: none)
  task automatic test_run(input string nm, input int budget, input int k, input int j);
    int tout, e0, n;
    logic [1:0] st;
    n = (budget == 0) ? 0 : imin(budget, imin(k == 0 ? 1000 : k, j == 0 ? 1000 : j));
    if (budget == 0)  st = 2'b01;
    else if (j == n)  st = 2'b11;
    else if (k == n)  st = 2'b00;
    else              st = 2'b01;
    e0 = exec_total;
    drive_run(32'(budget), (k == 0) ? 32'hFFFF_FFFF : 32'(k), j, tout);
    checks++;
    if (tout != 0) begin
      errs++; $display("FAIL %s_timeout: done never rose, want done within %0d cycles", nm, n + 1);
    end
    checks++;
    if (exec_total - e0 != n) begin
      errs++; $display("FAIL %s_exec_cycles: got %0d, want %0d", nm, exec_total - e0, n);
    end
    checks++;
    if (cycles_run !== CW'(n) || status !== st) begin
      errs++; $display("FAIL %s_result: got cycles=%0d status=%b, want %0d %b",
                       nm, cycles_run, status, n, st);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || exec !== 1'b0) begin
      errs++; $display("FAIL %s_flags: got done=%b busy=%b exec=%b, want 1 0 0",
                       nm, done, busy, exec);
    end
  endtask

  task automatic test_abort_load;
    int base;
    base = wr_q.size();
    @(negedge clk); start_load = 1'b1;
    @(negedge clk); start_load = 1'b0;
    bus.ld_valid = 1'b1; bus.ld_data = 32'hA0A0_0001;
    @(negedge clk); bus.ld_data = 32'hA0A0_0002;
    @(negedge clk); bus.ld_data = 32'hA0A0_0003; abort = 1'b1;
    @(negedge clk); abort = 1'b0; bus.ld_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (wr_q.size() - base != 2) begin
      errs++; $display("FAIL abort_load_writes: got %0d, want 2", wr_q.size() - base);
    end
    checks++;
    if (status !== 2'b11 || done !== 1'b1 || words_loaded !== (AW+1)'(2) || bus.ld_ready !== 1'b0) begin
      errs++; $display("FAIL abort_load_end: got st=%b done=%b words=%0d rdy=%b, want 11 1 2 0",
                       status, done, words_loaded, bus.ld_ready);
    end
  endtask

  task automatic test_reset_mid_run;
    int e0;
    @(negedge clk);
    run_start = 1'b1; run_cycles = 50; halt_pc = '1;
    @(negedge clk);
    run_start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (exec !== 1'b1) begin
      errs++; $display("FAIL rstrun_pre: got exec=%b, want 1", exec);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({exec, busy, done, status, words_loaded, cycles_run,
         bus.ld_ready, bus.mem_we, bus.mem_a, bus.mem_d} !== '0) begin
      errs++; $display("FAIL rstrun_zero: got exec=%b busy=%b done=%b st=%b cyc=%0d, want all 0",
                       exec, busy, done, status, cycles_run);
    end
    rst = 1'b0; start_load = 1'b1; run_start = 1'b1; run_cycles = 5;
    e0 = exec_total;
    @(negedge clk);
    start_load = 1'b0; run_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || exec !== 1'b0 || bus.ld_ready !== 1'b1) begin
      errs++; $display("FAIL both_starts: got busy=%b exec=%b rdy=%b, want 1 0 1",
                       busy, exec, bus.ld_ready);
    end
    repeat (3) @(negedge clk);
    bus.ld_valid = 1'b1; bus.ld_last = 1'b1; bus.ld_data = 32'h1234_5678;
    @(negedge clk);
    bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (exec_total != e0 || busy !== 1'b0 || words_loaded !== (AW+1)'(1)) begin
      errs++; $display("FAIL both_starts_end: got execs=%0d busy=%b words=%0d, want 0 0 1",
                       exec_total - e0, busy, words_loaded);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(1, 0) == 1) begin
        int n, la;
        n  = $urandom_range(6, 1);
        la = (n >= MW && $urandom_range(1, 0) == 1) ? -1 : int'($urandom_range(n - 1, 0));
        test_load($sformatf("rnd%0d_load", it), n, la, 0, 2);
      end else begin
        int b, k, j;
        b = $urandom_range(20, 0);
        k = ($urandom_range(1, 0) == 1) ? int'($urandom_range(25, 1)) : 0;
        j = ($urandom_range(3, 0) == 0) ? int'($urandom_range(25, 1)) : 0;
        test_run($sformatf("rnd%0d_run", it), b, k, j);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start_load = 1'b0; run_start = 1'b0; abort = 1'b0;
    run_cycles = '0; halt_pc = '0; pc_in = '0;
    bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
    test_reset;
    test_load("basic", 4, 3, 0, 0);
    test_load("gaps", 3, 2, 2, 2);
    test_load("overflow", 6, -1, 0, 0);
    test_run("budget", 10, 0, 0);
    test_run("halt", 100, 5, 0);
    test_run("zero_budget", 0, 0, 0);
    test_run("halt_eq_budget", 7, 7, 0);
    test_run("abort_over_halt", 20, 4, 4);
    test_abort_load;
    test_random;
    test_reset_mid_run;
    checks++;
    if (overlap != 0) begin
      errs++; $display("FAIL we_exec_overlap: got %0d cycles, want 0", overlap);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end
endmodule
